// File: rtl/add_sub_pkg.sv
// Shared types and encodings for the arbitrated add/sub unit.
package add_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_arb_if.sv
// Requester bundle and result handshake for add_sub_arb.
interface add_sub_arb_if #(
  parameter int N = 8,
  parameter int R = 4
);
  localparam int IW = $clog2(R);

  logic [R-1:0]         req_vld;
  logic [R-1:0]         req_rdy;
  logic [R-1:0][N-1:0]  a;
  logic [R-1:0][N-1:0]  b;
  logic [R-1:0]         sel;
  logic                 res_vld;
  logic                 res_rdy;
  logic [N-1:0]         res;
  logic [IW-1:0]        res_id;

  // Requesters and result consumer
  modport master (
    output req_vld, a, b, sel, res_rdy,
    input  req_rdy, res_vld, res, res_id
  );

  // Arbitrated add/sub unit
  modport slave (
    input  req_vld, a, b, sel, res_rdy,
    output req_rdy, res_vld, res, res_id
  );

endinterface

// File: rtl/add_sub_n.sv
// N-bit modular adder/subtractor; sel chooses a-b over a+b.
module add_sub_n
  import add_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sel_i,
  output logic [N-1:0] y_o
);

  assign y_o = (sel_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/add_sub_arb.sv
// Round-robin arbiter feeding one shared adder/subtractor into a single-entry
// result register with valid/ready handshake.
module add_sub_arb
  import add_sub_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [R-1:0]        req_vld_in,
  output logic [R-1:0]        req_rdy_o,
  input  logic [R-1:0][N-1:0] a_in,
  input  logic [R-1:0][N-1:0] b_in,
  input  logic [R-1:0]        sel_in,
  output logic                res_vld_o,
  input  logic                res_rdy_in,
  output logic [N-1:0]        res_o,
  output logic [IW-1:0]       res_id_o
);

  localparam logic [IW-1:0] LAST_RST = IW'(R - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] last_q;
  logic [IW-1:0] res_id_q;
  logic [N-1:0]  res_q;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          found;
  logic          accept;
  logic [N-1:0]  alu_y;

  // Search upward from the slot after the last transfer, wrapping at R.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= R; k++) begin
      cand = IW'((int'(last_q) + k) % R);
      if (!found && req_vld_in[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign accept = !rst_in && found && ((state_q == IDLE) || res_rdy_in);

  for (genvar gi = 0; gi < R; gi++) begin : g_rdy
    assign req_rdy_o[gi] = accept && (win_idx == IW'(gi));
  end

  add_sub_n #(.N(N)) u_alu (
    .a_i   (a_in[win_idx]),
    .b_i   (b_in[win_idx]),
    .sel_i (sel_in[win_idx]),
    .y_o   (alu_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = FULL;
      FULL: begin
        if (accept)          state_d = FULL;
        else if (res_rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q   <= win_idx;
        res_q    <= alu_y;
        res_id_q <= win_idx;
      end
    end
  end

  assign res_vld_o = (state_q == FULL);
  assign res_o     = res_q;
  assign res_id_o  = res_id_q;

endmodule

// File: tb/tb_add_sub_arb.sv
// Directed bench for add_sub_arb: a behavioural model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_add_sub_arb;

  localparam int N = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;

  add_sub_arb_if #(.N(N), .R(R)) bus ();

  add_sub_arb #(.N(N), .R(R)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .req_vld_in (bus.req_vld),
    .req_rdy_o  (bus.req_rdy),
    .a_in       (bus.a),
    .b_in       (bus.b),
    .sel_in     (bus.sel),
    .res_vld_o  (bus.res_vld),
    .res_rdy_in (bus.res_rdy),
    .res_o      (bus.res),
    .res_id_o   (bus.res_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Literal expectation slot, filled by stimulus, consumed at the next negedge
  int          lit_wr = 0;
  int          lit_rd = 0;
  string       lit_name;
  logic [3:0]  lit_rdy;
  logic        lit_vld;
  logic [7:0]  lit_res;
  logic [1:0]  lit_id;
  bit          lit_data;

  // Model state
  int          m_last = R - 1;
  bit          m_vld  = 1'b0;
  logic [7:0]  m_res  = '0;
  int          m_id   = 0;
  int          n_last;
  bit          n_vld;
  logic [7:0]  n_res;
  int          n_id;
  int          w;
  bit          acc;
  logic [3:0]  exp_rdy;

  function automatic int rr_pick(int last, logic [3:0] v);
    for (int k = 1; k <= R; k++) begin
      if (v[(last + k) % R]) return (last + k) % R;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    if (rst) begin
      m_vld  = 1'b0;
      m_res  = '0;
      m_id   = 0;
      m_last = R - 1;
    end
    w       = rr_pick(m_last, bus.req_vld);
    acc     = !rst && (w >= 0) && (!m_vld || bus.res_rdy);
    exp_rdy = acc ? 4'(1 << w) : 4'b0000;

    chk("model_req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    chk("model_res_vld", 32'(bus.res_vld), 32'(m_vld));
    if (m_vld || rst) begin
      chk("model_res", 32'(bus.res), 32'(m_res));
      chk("model_res_id", 32'(bus.res_id), 32'(m_id));
    end

    if (lit_wr != lit_rd) begin
      chk({lit_name, "_rdy"}, 32'(bus.req_rdy), 32'(lit_rdy));
      chk({lit_name, "_vld"}, 32'(bus.res_vld), 32'(lit_vld));
      if (lit_data) begin
        chk({lit_name, "_res"}, 32'(bus.res), 32'(lit_res));
        chk({lit_name, "_id"}, 32'(bus.res_id), 32'(lit_id));
      end
      $display("[TB] check %s rdy=%b vld=%0d res=%0d id=%0d", lit_name,
               bus.req_rdy, bus.res_vld, bus.res, bus.res_id);
      lit_rd = lit_wr;
    end

    n_last = m_last;
    n_vld  = m_vld;
    n_res  = m_res;
    n_id   = m_id;
    if (acc) begin
      n_vld  = 1'b1;
      n_res  = bus.sel[w] ? (bus.a[w] - bus.b[w]) : (bus.a[w] + bus.b[w]);
      n_id   = w;
      n_last = w;
    end else if (m_vld && bus.res_rdy) begin
      n_vld = 1'b0;
    end

    @(posedge clk);
    if (!rst) begin
      m_last = n_last;
      m_vld  = n_vld;
      m_res  = n_res;
      m_id   = n_id;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string nm, logic [3:0] rdy, logic v, logic [7:0] r,
                     logic [1:0] id, bit d);
    lit_name = nm;
    lit_rdy  = rdy;
    lit_vld  = v;
    lit_res  = r;
    lit_id   = id;
    lit_data = d;
    lit_wr++;
  endtask

  initial begin
    rst         = 1'b1;
    bus.req_vld = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.sel     = '0;
    bus.res_rdy = 1'b0;

    step(); lit("reset", 4'b0000, 1'b0, 8'd0, 2'd0, 1'b1);
    step();
    step();

    // First accept right after reset release: 200+100 wraps to 44
    rst = 1'b0;
    bus.req_vld = 4'b0001;
    bus.a[0] = 8'd200; bus.b[0] = 8'd100; bus.sel[0] = 1'b0;
    bus.res_rdy = 1'b1;
    lit("t030_grant", 4'b0001, 1'b0, 8'd0, 2'd0, 1'b0);
    step(); bus.req_vld = 4'b0000;
    lit("t030_res", 4'b0000, 1'b1, 8'd44, 2'd0, 1'b1);
    step(); lit("t030_drain", 4'b0000, 1'b0, 8'd0, 2'd0, 1'b0);

    // Requester 2 computes 5-7 = 254, held under backpressure
    step();
    bus.req_vld = 4'b0100;
    bus.a[2] = 8'd5; bus.b[2] = 8'd7; bus.sel[2] = 1'b1;
    bus.res_rdy = 1'b0;
    lit("t032_grant", 4'b0100, 1'b0, 8'd0, 2'd0, 1'b0);
    step(); bus.req_vld = 4'b1001;
    lit("t032_hold0", 4'b0000, 1'b1, 8'd254, 2'd2, 1'b1);
    step(); lit("t032_hold1", 4'b0000, 1'b1, 8'd254, 2'd2, 1'b1);
    step(); lit("t032_hold2", 4'b0000, 1'b1, 8'd254, 2'd2, 1'b1);
    step(); bus.req_vld = 4'b0000; bus.res_rdy = 1'b1;
    lit("t032_drainc", 4'b0000, 1'b1, 8'd254, 2'd2, 1'b1);
    step(); lit("t032_empty", 4'b0000, 1'b0, 8'd0, 2'd0, 1'b0);

    // Fill with 10+3, then swap in requester 3's 100-1 in the draining cycle
    step();
    bus.req_vld = 4'b0001;
    bus.a[0] = 8'd10; bus.b[0] = 8'd3; bus.sel[0] = 1'b0;
    bus.res_rdy = 1'b0;
    lit("t033_g0", 4'b0001, 1'b0, 8'd0, 2'd0, 1'b0);
    step();
    bus.req_vld = 4'b1000;
    bus.a[3] = 8'd100; bus.b[3] = 8'd1; bus.sel[3] = 1'b1;
    bus.res_rdy = 1'b1;
    lit("t033_swap", 4'b1000, 1'b1, 8'd13, 2'd0, 1'b1);
    step(); bus.req_vld = 4'b0000; bus.res_rdy = 1'b0;
    lit("t033_new", 4'b0000, 1'b1, 8'd99, 2'd3, 1'b1);

    // All four requesting: 1+0, 11-1, 21+2, 31-3 granted in rotation
    step();
    for (int i = 0; i < R; i++) begin
      bus.a[i] = 8'(i * 10 + 1);
      bus.b[i] = 8'(i);
    end
    bus.sel = 4'b1010;
    bus.req_vld = 4'b1111;
    bus.res_rdy = 1'b1;
    lit("t031_g0", 4'b0001, 1'b1, 8'd99, 2'd3, 1'b1);
    step(); lit("t031_g1", 4'b0010, 1'b1, 8'd1, 2'd0, 1'b1);
    step(); lit("t031_g2", 4'b0100, 1'b1, 8'd10, 2'd1, 1'b1);
    step(); lit("t031_g3", 4'b1000, 1'b1, 8'd23, 2'd2, 1'b1);
    step(); lit("t031_g0b", 4'b0001, 1'b1, 8'd28, 2'd3, 1'b1);
    step(); bus.res_rdy = 1'b0;
    lit("t034_full", 4'b0000, 1'b1, 8'd1, 2'd0, 1'b1);

    // Reset mid-cycle while full with requests pending
    step(); rst = 1'b1;
    lit("t034_rst", 4'b0000, 1'b0, 8'd0, 2'd0, 1'b1);
    step();
    step(); rst = 1'b0; bus.res_rdy = 1'b1;
    lit("t034_first", 4'b0001, 1'b0, 8'd0, 2'd0, 1'b1);
    step(); bus.req_vld = 4'b0010; bus.res_rdy = 1'b0;
    lit("t034_res", 4'b0000, 1'b1, 8'd1, 2'd0, 1'b1);

    // Requester 1 withdraws unserved; requester 2 wins next
    step(); bus.req_vld = 4'b0100; bus.res_rdy = 1'b1;
    lit("t025_drop", 4'b0100, 1'b1, 8'd1, 2'd0, 1'b1);
    step(); bus.req_vld = 4'b0000;
    lit("t025_res", 4'b0000, 1'b1, 8'd23, 2'd2, 1'b1);
    step(); lit("t025_end", 4'b0000, 1'b0, 8'd0, 2'd0, 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
